fp_mul_seq: RTL

//  Sequential IEEE-754 single-precision multiplier; consumes two float_pkg::float operands, produces float product.

---
 rtl/fp_mul_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fp_mul_seq.sv
// Sequential single-precision float multiplier: shift-add mantissa product, truncating rounding,
// denormal flush, canonical quiet NaN, valid/ready handshake on both sides.
module fp_mul_seq #(
   parameter int EXP_BITS       = 8,
   parameter int FRAC_BITS      = 23,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [EXP_BITS+FRAC_BITS:0]   a,
   input  logic [EXP_BITS+FRAC_BITS:0]   b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [EXP_BITS+FRAC_BITS:0]   result,
   output logic [2:0]                    flags
);

   localparam int W    = 1 + EXP_BITS + FRAC_BITS;
   localparam int MW   = FRAC_BITS + 1;
   localparam int PW   = 2 * MW;
   localparam int N    = MW / BITS_PER_CYCLE;
   localparam int CW   = $clog2(N + 1);
   localparam int EW   = EXP_BITS + 2;
   localparam int EMAX = (1 << EXP_BITS) - 1;
   localparam int BIAS = EMAX >> 1;

   localparam logic [W-1:0] QNAN = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    sign_q, sign_d;
   logic [EXP_BITS-1:0]     ea_q, ea_d, eb_q, eb_d;
   logic [PW-1:0]           mcand_q, mcand_d;
   logic [MW-1:0]           mplier_q, mplier_d;
   logic [PW-1:0]           acc_q, acc_d;
   logic [W-1:0]            result_q, result_d;
   logic [2:0]              flags_q, flags_d;

   logic [EXP_BITS-1:0]     a_exp, b_exp;
   logic [FRAC_BITS-1:0]    a_frac, b_frac;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special;
   logic [W+2:0]            special_pack, norm_pack;
   logic [PW-1:0]           step_sum;
   logic signed [EW-1:0]    e_norm;
   logic [FRAC_BITS-1:0]    m_norm;

   // Saturate the biased exponent into a packed {flags, float}: overflow to inf, underflow to zero.
   function automatic logic [W+2:0] pack_result(input logic sgn,
                                                input logic signed [EW-1:0] e,
                                                input logic [FRAC_BITS-1:0] m);
      if (e >= $signed(EW'(EMAX)))
         pack_result = {3'b010, sgn, {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
      else if (e <= $signed(EW'(0)))
         pack_result = {3'b001, sgn, {EXP_BITS{1'b0}}, {FRAC_BITS{1'b0}}};
      else
         pack_result = {3'b000, sgn, e[EXP_BITS-1:0], m};
   endfunction

   assign a_exp  = a[W-2:FRAC_BITS];
   assign b_exp  = b[W-2:FRAC_BITS];
   assign a_frac = a[FRAC_BITS-1:0];
   assign b_frac = b[FRAC_BITS-1:0];
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == EXP_BITS'(EMAX)) && (a_frac == '0);
   assign b_inf  = (b_exp == EXP_BITS'(EMAX)) && (b_frac == '0);
   assign a_nan  = (a_exp == EXP_BITS'(EMAX)) && (a_frac != '0);
   assign b_nan  = (b_exp == EXP_BITS'(EMAX)) && (b_frac != '0);
   assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

   always_comb begin
      special_pack = {3'b000, a[W-1] ^ b[W-1], {(W-1){1'b0}}};
      if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf))
         special_pack = {3'b100, QNAN};
      else if (a_inf | b_inf)
         special_pack = {3'b000, a[W-1] ^ b[W-1], {EXP_BITS{1'b1}}, {FRAC_BITS{1'b0}}};
   end

   // One MUL cycle retires BITS_PER_CYCLE multiplier bits into the accumulator.
   always_comb begin
      step_sum = acc_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++)
         if (mplier_q[i]) step_sum = step_sum + (mcand_q << i);
   end

   always_comb begin
      e_norm = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(EW'(BIAS))
             + $signed({{(EW-1){1'b0}}, acc_q[PW-1]});
      m_norm = acc_q[PW-1] ? acc_q[PW-2:MW] : acc_q[PW-3:MW-1];
      norm_pack = pack_result(sign_q, e_norm, m_norm);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sign_d    = sign_q;
      ea_d      = ea_q;
      eb_d      = eb_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      result_d  = result_q;
      flags_d   = flags_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               sign_d   = a[W-1] ^ b[W-1];
               ea_d     = a_exp;
               eb_d     = b_exp;
               mcand_d  = {{(PW-MW){1'b0}}, 1'b1, a_frac};
               mplier_d = {1'b1, b_frac};
               acc_d    = '0;
               cnt_d    = '0;
               if (is_special) begin
                  {flags_d, result_d} = special_pack;
                  state_d = S_DONE;
               end else begin
                  state_d = S_MUL;
               end
            end
         end
         S_MUL: begin
            acc_d    = step_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = S_NORM;
         end
         S_NORM: begin
            {flags_d, result_d} = norm_pack;
            state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         ea_q     <= '0;
         eb_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sign_q   <= sign_d;
         ea_q     <= ea_d;
         eb_q     <= eb_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign result = result_q;
   assign flags  = flags_q;

endmodule
